// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word read per accepted fetch, loads the IR,
// and strobes the next-sequential PC. Misaligned PCs and unacknowledged reads raise a sticky fault.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_start_i,
    input  logic [31:0] pc_in_i,
    input  logic        flush_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] ir_out_o,
    output logic        ir_valid_o,
    output logic        pc_load_o,
    output logic [31:0] pc_next_o,
    output logic        busy_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam int unsigned          WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e              state_q;
    logic                mem_req_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         ir_q;
    logic                ir_valid_q;
    logic                pc_load_q;
    logic [31:0]         pc_next_q;
    logic [1:0]          fault_code_q;
    logic [WAIT_W-1:0]   wait_q;

    logic [31:0]         pc_next_d;
    logic [WAIT_W-1:0]   wait_d;

    // The 32-bit add wraps naturally, so 0xFFFFFFFC advances to 0x00000000.
    assign pc_next_d = mem_addr_q + 32'd4;
    assign wait_d    = wait_q + WAIT_W'(1);

    // NOTE: every register here is sequential state, so it is written with <= only;
    // blocking assignments would let later statements see half-updated values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_next_q    <= '0;
            fault_code_q <= FC_NONE;
            wait_q       <= '0;
        end else if (flush_i) begin
            // Flush beats any same-cycle ack or fetch: nothing is latched and no PC load follows.
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            ir_valid_q   <= 1'b0;
            pc_load_q    <= 1'b0;
            fault_code_q <= FC_NONE;
            wait_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_start_i) begin
                        if (pc_in_i[1:0] == 2'b00) begin
                            mem_addr_q <= pc_in_i;
                            mem_req_q  <= 1'b1;
                            ir_valid_q <= 1'b0;
                            wait_q     <= '0;
                            state_q    <= REQ;
                        end else begin
                            fault_code_q <= FC_MISALIGN;
                            state_q      <= FAULT;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        ir_q       <= mem_rdata_i;
                        ir_valid_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        pc_load_q  <= 1'b1;
                        pc_next_q  <= pc_next_d;
                        state_q    <= DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        mem_req_q    <= 1'b0;
                        fault_code_q <= FC_TIMEOUT;
                        state_q      <= FAULT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                DONE: begin
                    pc_load_q <= 1'b0;
                    state_q   <= IDLE;
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign ir_out_o     = ir_q;
    assign ir_valid_o   = ir_valid_q;
    assign pc_load_o    = pc_load_q;
    assign pc_next_o    = pc_next_q;
    assign busy_o       = (state_q != IDLE);
    assign fault_o      = (state_q == FAULT);
    assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: the driver predicts each fetch's
// outcome from the fetch rules and a monitor compares it whenever the DUT reports one.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_start_i = 1'b0;
    logic [31:0] pc_in_i = '0;
    logic        flush_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] ir_out_o;
    logic        ir_valid_o;
    logic        pc_load_o;
    logic [31:0] pc_next_o;
    logic        busy_o;
    logic        fault_o;
    logic [1:0]  fault_code_o;

    instr_fetch_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fetch_start_i(fetch_start_i),
        .pc_in_i      (pc_in_i),
        .flush_i      (flush_i),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .ir_out_o     (ir_out_o),
        .ir_valid_o   (ir_valid_o),
        .pc_load_o    (pc_load_o),
        .pc_next_o    (pc_next_o),
        .busy_o       (busy_o),
        .fault_o      (fault_o),
        .fault_code_o (fault_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int { EV_LOAD = 1, EV_FAULT = 2 } ev_kind_e;

    typedef struct {
        ev_kind_e    kind;
        logic [31:0] ir;
        logic [31:0] pc_next;
        logic [1:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_ir   = '0;
    logic [31:0] last_addr = '0;
    logic        fault_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one prediction per reported outcome (PC load strobe or fault entry).
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            fault_prev = 1'b0;
        end else begin
            if (pc_load_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pc_load", 32'(pc_load_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("load_kind", 32'(EV_LOAD), 32'(e.kind));
                    check("load_ir_out", ir_out_o, e.ir);
                    check("load_ir_valid", 32'(ir_valid_o), 32'd1);
                    check("load_pc_next", pc_next_o, e.pc_next);
                end
            end
            if (fault_o && !fault_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fault", 32'(fault_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("fault_kind", 32'(EV_FAULT), 32'(e.kind));
                    check("fault_code", 32'(fault_code_o), 32'(e.code));
                    check("fault_mem_req", 32'(mem_req_o), 32'd0);
                end
            end
            fault_prev = fault_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_fault", 32'(fault_o), 32'd0);
        check("flush_code", 32'(fault_code_o), 32'd0);
        check("flush_ir_valid", 32'(ir_valid_o), 32'd0);
    endtask

    // One fetch. delay = cycles in REQ before the ack; delay >= MAX_WAIT means no ack at all.
    task automatic do_fetch(input logic [31:0] pc, input int delay, input bit race,
                            input logic [31:0] rdata);
        exp_t e;
        int   cnt;
        logic [31:0] junk;
        if (pc[1:0] != 2'b00) begin
            e = '{kind: EV_FAULT, ir: '0, pc_next: '0, code: 2'b01};
            exp_q.push_back(e);
            fetch_start_i = 1'b1;
            pc_in_i = pc;
            step();
            fetch_start_i = 1'b0;
            check("misalign_mem_req", 32'(mem_req_o), 32'd0);
            repeat (3) step();
            check("misalign_sticky", 32'(fault_o), 32'd1);
            check("misalign_code_held", 32'(fault_code_o), 32'd1);
            check("misalign_mem_req_held", 32'(mem_req_o), 32'd0);
            do_flush();
            return;
        end
        if (delay >= MAX_WAIT) begin
            e = '{kind: EV_FAULT, ir: '0, pc_next: '0, code: 2'b10};
            exp_q.push_back(e);
        end else if (!race) begin
            e = '{kind: EV_LOAD, ir: rdata, pc_next: pc + 32'd4, code: 2'b00};
            exp_q.push_back(e);
        end
        fetch_start_i = 1'b1;
        pc_in_i = pc;
        step();
        fetch_start_i = 1'b0;
        last_addr = pc;
        check("accept_ir_valid_clear", 32'(ir_valid_o), 32'd0);
        if (delay >= MAX_WAIT) begin
            cnt = 0;
            for (int i = 0; i < 3 * MAX_WAIT; i++) begin
                if (!mem_req_o) break;
                check("timeout_addr_stable", mem_addr_o, pc);
                cnt++;
                step();
            end
            check("timeout_req_cycles", 32'(cnt), 32'(MAX_WAIT));
            check("timeout_fault", 32'(fault_o), 32'd1);
            check("timeout_code", 32'(fault_code_o), 32'd2);
            repeat (2) step();
            check("timeout_sticky", 32'(fault_o), 32'd1);
            do_flush();
            return;
        end
        for (int i = 0; i < delay; i++) begin
            check("req_mem_req", 32'(mem_req_o), 32'd1);
            check("req_addr_stable", mem_addr_o, pc);
            junk = $urandom;
            fetch_start_i = junk[0];
            pc_in_i = {junk[31:2], 2'b00} ^ 32'h0000_0100;
            mem_rdata_i = $urandom;
            step();
            fetch_start_i = 1'b0;
        end
        check("ack_cycle_mem_req", 32'(mem_req_o), 32'd1);
        check("ack_cycle_addr", mem_addr_o, pc);
        mem_ack_i = 1'b1;
        mem_rdata_i = rdata;
        flush_i = race;
        step();
        mem_ack_i = 1'b0;
        flush_i = 1'b0;
        if (race) begin
            check("race_busy", 32'(busy_o), 32'd0);
            check("race_ir_valid", 32'(ir_valid_o), 32'd0);
            check("race_ir_unchanged", ir_out_o, last_ir);
            check("race_no_pc_load", 32'(pc_load_o), 32'd0);
            step();
        end else begin
            last_ir = rdata;
            check("done_busy", 32'(busy_o), 32'd1);
            step();
            check("idle_after_done", 32'(busy_o), 32'd0);
            check("pc_load_one_cycle", 32'(pc_load_o), 32'd0);
            check("ir_valid_held", 32'(ir_valid_o), 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_ir_out"}, ir_out_o, 32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid_o), 32'd0);
        check({tag, "_pc_load"}, 32'(pc_load_o), 32'd0);
        check({tag, "_pc_next"}, pc_next_o, 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_fault"}, 32'(fault_o), 32'd0);
        check({tag, "_fault_code"}, 32'(fault_code_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] pc;
        int          kind;

        repeat (3) step();
        check_all_zero("reset");
        rst_ni = 1'b1;
        repeat (3) step();
        check_all_zero("post_reset_quiet");

        do_fetch(32'h0000_0010, 0, 1'b0, 32'h8C22_0004);
        do_fetch(32'h0000_0006, 0, 1'b0, 32'h0);
        do_fetch(32'h0000_0040, MAX_WAIT, 1'b0, 32'h0);
        do_fetch(32'hFFFF_FFFC, 2, 1'b0, 32'h1234_5678);
        do_fetch(32'h0000_0080, 1, 1'b1, 32'hAAAA_5555);
        do_fetch(32'h0000_0100, MAX_WAIT - 1, 1'b0, 32'hCAFE_F00D);

        // Stray ack in IDLE must not touch the IR.
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        repeat (2) step();
        mem_ack_i = 1'b0;
        check("idle_ack_ir", ir_out_o, last_ir);
        check("idle_ack_busy", 32'(busy_o), 32'd0);

        // Flush and fetch_start together in IDLE: fetch is dropped.
        flush_i = 1'b1;
        fetch_start_i = 1'b1;
        pc_in_i = 32'h0000_0200;
        step();
        flush_i = 1'b0;
        fetch_start_i = 1'b0;
        check("flush_fetch_busy", 32'(busy_o), 32'd0);
        check("flush_fetch_mem_req", 32'(mem_req_o), 32'd0);
        check("flush_fetch_addr", mem_addr_o, last_addr);

        // Asynchronous reset mid-fetch.
        fetch_start_i = 1'b1;
        pc_in_i = 32'h0000_0300;
        step();
        fetch_start_i = 1'b0;
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        last_ir = '0;
        last_addr = '0;
        step();
        step();
        rst_ni = 1'b1;
        repeat (2) step();
        check_all_zero("post_reset2_quiet");
        do_fetch(32'h0000_0400, 0, 1'b0, 32'h0BAD_C0DE);

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            pc = {r[31:2], 2'b00};
            kind = $urandom_range(0, 9);
            if (kind == 9) pc = 32'hFFFF_FFFC;
            case (kind)
                0:       do_fetch(pc | 32'($urandom_range(1, 3)), 0, 1'b0, 32'h0);
                1:       do_fetch(pc, MAX_WAIT + $urandom_range(0, 3), 1'b0, 32'h0);
                2:       do_fetch(pc, $urandom_range(0, MAX_WAIT - 1), 1'b1, $urandom);
                default: do_fetch(pc, $urandom_range(0, MAX_WAIT - 1), 1'b0, $urandom);
            endcase
        end

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
